// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// Also used by uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Cycles per bit, or per half bit when half is set; both truncate.
  function automatic int bit_cycles(input int clk_hz, input int bit_rate, input logic half);
    int full;
    full = clk_hz / bit_rate;
    return half ? (full / 2) : full;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to RESET_VAL
// (idle-high by default).
module uart_rx_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with break and framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_break,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_parity_err
);

  localparam int CYCLES_PER_BIT = bit_cycles(CLK_HZ, BIT_RATE, 1'b0);
  localparam int HALF_BIT       = bit_cycles(CLK_HZ, BIT_RATE, 1'b1);
  localparam int CNT_W          = clog2(CYCLES_PER_BIT + 1);
  localparam int IDX_W          = clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  logic rxd_s;

  uart_rx_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (uart_rxd),
    .sync_o  (rxd_s)
  );

  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        bit_q, bit_d;
  logic [1:0]              stop_q, stop_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    stop_bad_q, stop_bad_d;
  logic                    wait_high_q, wait_high_d;
  logic                    valid_q, valid_d;
  logic                    break_q, break_d;
  logic                    ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad_q, par_bad_d;
  logic                    perr_q, perr_d;
`endif
  logic                    bad_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    data_d      = data_q;
    stop_bad_d  = stop_bad_q;
    wait_high_d = wait_high_q;
    valid_d     = 1'b0;
    break_d     = 1'b0;
    ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    perr_d      = 1'b0;
`endif
    bad_s       = stop_bad_q | ~rxd_s;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // After a low stop bit the line must go high before a new start edge counts.
        if (wait_high_q) begin
          wait_high_d = ~rxd_s;
        end else if (uart_rx_en && !rxd_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            stop_d     = 2'd0;
            stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) != rxd_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (stop_q == LAST_STOP) begin
            // Leave at the sample point so a following start edge is not missed.
            state_d     = IDLE;
            wait_high_d = bad_s;
            if (bad_s) begin
              if (shift_q == '0) begin
                break_d = 1'b1;
              end else begin
                ferr_d = 1'b1;
              end
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            stop_d     = stop_q + 2'd1;
            stop_bad_d = bad_s;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 2'd0;
      shift_q     <= '0;
      data_q      <= '0;
      stop_bad_q  <= 1'b0;
      wait_high_q <= 1'b0;
      valid_q     <= 1'b0;
      break_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      stop_bad_q  <= stop_bad_d;
      wait_high_q <= wait_high_d;
      valid_q     <= valid_d;
      break_q     <= break_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_break     = break_q;
  assign uart_rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = perr_q;
`else
  assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit: stimulus pushes expected
// strobes, a forked monitor pops and compares whenever any strobe fires.
module tb_uart_rx;

  localparam int CPB = 10;
  localparam logic [3:0] K_VALID = 4'b0001;
  localparam logic [3:0] K_BREAK = 4'b0010;
  localparam logic [3:0] K_FERR  = 4'b0100;
  localparam logic [3:0] K_PERR  = 4'b1000;

  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_break;
  logic       uart_rx_frame_err;
  logic       uart_rx_parity_err;

  int   vec_cnt;
  int   miss_cnt;
  int   cyc;
  exp_t exp_q[$];
  int   valid_cyc[$];

  uart_rx #(
    .CLK_HZ       (1000000),
    .BIT_RATE     (100000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rxd           (uart_rxd),
    .uart_rx_en         (uart_rx_en),
    .uart_rx_data       (uart_rx_data),
    .uart_rx_valid      (uart_rx_valid),
    .uart_rx_break      (uart_rx_break),
    .uart_rx_frame_err  (uart_rx_frame_err),
    .uart_rx_parity_err (uart_rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] strobes();
    return {uart_rx_parity_err, uart_rx_frame_err, uart_rx_break, uart_rx_valid};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt = vec_cnt + 1;
    if (act !== expv) begin
      miss_cnt = miss_cnt + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (strobes() != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {20'd0, strobes(), uart_rx_data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {28'd0, strobes()}, {28'd0, e.kind});
          check("strobe_data", {24'd0, uart_rx_data}, {24'd0, e.data});
          if (strobes() == K_VALID) valid_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`endif
    send_bit(stop_v);
  endtask

  task automatic push(input logic [3:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    vec_cnt    = 0;
    miss_cnt   = 0;
    cyc        = 0;
    reset      = 1'b1;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, uart_rx_data}, 32'd0);
    check("reset_strobes", {28'd0, strobes()}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Good frame
    push(K_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // Break: all-zero data, stop low, line held low a while
    push(K_BREAK, 8'hA5);
    send_frame(8'h00, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);

    // Framing error
    push(K_FERR, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b1);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);

    // Short glitch must be rejected
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_data_hold", {24'd0, uart_rx_data}, 32'h000000A5);

    // Enable low: whole frame ignored
    uart_rx_en = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    uart_rx_en = 1'b1;
    repeat (20) @(negedge clk);
    check("disabled_data_hold", {24'd0, uart_rx_data}, 32'h000000A5);

    // Back-to-back frames, no idle gap
    valid_cyc.delete();
    push(K_VALID, 8'h01);
    push(K_VALID, 8'hFF);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", valid_cyc.size(), 32'd2);
    gap = (valid_cyc.size() == 2) ? (valid_cyc[1] - valid_cyc[0]) : 0;
`ifdef UART_RX_PARITY_EN
    check("b2b_gap", {31'd0, (gap >= 109 && gap <= 111)}, 32'd1);
`else
    check("b2b_gap", {31'd0, (gap >= 99 && gap <= 101)}, 32'd1);
`endif

    // Reset in the middle of a 0x77 frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_data", {24'd0, uart_rx_data}, 32'd0);
    check("midreset_strobes", {28'd0, strobes()}, 32'd0);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    push(K_PERR, 8'h00);
    send_frame(8'h12, 1'b1, 1'b0);
`else
    push(K_VALID, 8'h12);
    send_frame(8'h12, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
